// File: rtl/pps_gen_pkg.sv
// Shared constants and helpers for the PPS / heartbeat timebase.
//   CLK_HZ_XGMII, CLK_HZ_BOARD : common domain clock rates (cycles per second)
//   SEC_W                      : seconds counter width
//   HB_MAX                     : upper bound on the number of heartbeat outputs
//   clamp_period()             : raises any requested period below 2 cycles to 2
package pps_gen_pkg;

    localparam int unsigned CLK_HZ_XGMII = 156250000;
    localparam int unsigned CLK_HZ_BOARD = 50000000;
    localparam int unsigned SEC_W        = 32;
    localparam int unsigned HB_MAX       = 32;

    // A 1-cycle period would make every cycle a wrap cycle; 2 is the shortest usable second.
    function automatic logic [31:0] clamp_period(input logic [31:0] period);
        return (period < 32'd2) ? 32'd2 : period;
    endfunction

endpackage

// File: rtl/pps_sync_edge.sv
// Two-flop synchroniser followed by a registered rising-edge detector for an
// asynchronous external PPS pin. Only instantiated when PPS_ALIGN_EN is defined.
// edge_o is high for one cycle, three cycles after the pin rises.
//   clk_i   in  domain clock
//   rst_ni  in  async active-low reset
//   pps_i   in  asynchronous PPS pin
//   edge_o  out one-cycle rising-edge pulse
module pps_sync_edge (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic pps_i,
    output logic edge_o
);

    // sync_q[0..1] form the synchroniser, sync_q[2] is the previous synchronised level.
    logic [2:0] sync_q, sync_d;
    logic       edge_q, edge_d;

    always_comb begin
        sync_d = {sync_q[1:0], pps_i};
        edge_d = sync_q[1] & ~sync_q[2];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            edge_q <= edge_d;
        end
    end

    assign edge_o = edge_q;

endmodule

// File: rtl/pps_heartbeat_gen.sv
// Per-clock-domain timebase: 1 PPS strobe, 32-bit seconds counter and N_HB
// binary-divided heartbeat outputs, with a runtime-reloadable period.
// Optional feature macro: PPS_ALIGN_EN -- when defined, a rising edge on
// ext_pps_i (after synchronisation) forces a wrap and records the phase at
// which it arrived; when undefined, ext_pps_i is ignored and align_ofs_o is 0.
// Ports:
//   clk, resetn             domain clock, async active-low reset
//   enable                  1 = run, 0 = freeze timebase (pps_o forced low)
//   period_in/valid/ready   period reload handshake into a one-entry shadow
//   ext_pps_i               external PPS pin (PPS_ALIGN_EN only)
//   pps_o                   PPS strobe, PULSE_CYC cycles wide
//   sec_cnt_o               seconds elapsed
//   hb_o                    hb_o[i] toggles every 2**i seconds
//   phase_o                 current phase within the second
//   align_ofs_o             phase captured at the last external edge
// SEC_INIT presets the seconds counter at reset (bring-up and rollover testing).
module pps_heartbeat_gen
    import pps_gen_pkg::*;
#(
    parameter int unsigned      CLK_HZ    = CLK_HZ_XGMII,
    parameter int unsigned      CNT_W     = 28,
    parameter int unsigned      PULSE_CYC = 1,
    parameter int unsigned      N_HB      = 4,
    parameter logic [SEC_W-1:0] SEC_INIT  = '0
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             enable,
    input  logic [CNT_W-1:0] period_in,
    input  logic             period_valid,
    output logic             period_ready,
    input  logic             ext_pps_i,
    output logic             pps_o,
    output logic [SEC_W-1:0] sec_cnt_o,
    output logic [N_HB-1:0]  hb_o,
    output logic [CNT_W-1:0] phase_o,
    output logic [CNT_W-1:0] align_ofs_o
);

    localparam int unsigned PulseW = (PULSE_CYC < 2) ? 1 : $clog2(PULSE_CYC + 1);

    logic [CNT_W-1:0]  phase_q, phase_d;
    logic [CNT_W-1:0]  period_q, period_d;
    logic [CNT_W-1:0]  shadow_q, shadow_d;
    logic              shadow_vld_q, shadow_vld_d;
    logic              ready_q, ready_d;
    logic [PulseW-1:0] pulse_cnt_q, pulse_cnt_d;
    logic              pps_q, pps_d;
    logic [SEC_W-1:0]  sec_q, sec_d;
    logic [N_HB-1:0]   hb_q, hb_d;

    logic ext_edge;
    logic nat_wrap;
    logic wrap;
    logic xfer;

`ifdef PPS_ALIGN_EN
    logic [CNT_W-1:0] align_q, align_d;

    pps_sync_edge u_sync_edge (
        .clk_i  (clk),
        .rst_ni (resetn),
        .pps_i  (ext_pps_i),
        .edge_o (ext_edge)
    );

    always_comb begin
        align_d = align_q;
        if (enable && ext_edge) begin
            align_d = phase_q;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            align_q <= '0;
        end else begin
            align_q <= align_d;
        end
    end

    assign align_ofs_o = align_q;
`else
    logic unused_ext_pps;

    assign ext_edge       = 1'b0;
    assign unused_ext_pps = ext_pps_i;
    assign align_ofs_o    = '0;
`endif

    // A natural wrap and an external edge in the same cycle are one event.
    assign nat_wrap = enable && (phase_q == period_q - CNT_W'(1));
    assign wrap     = nat_wrap || (enable && ext_edge);
    assign xfer     = period_valid && ready_q;

    always_comb begin
        phase_d      = phase_q;
        period_d     = period_q;
        shadow_d     = shadow_q;
        shadow_vld_d = shadow_vld_q;
        ready_d      = ready_q;
        sec_d        = sec_q;
        hb_d         = hb_q;
        pulse_cnt_d  = '0;
        pps_d        = 1'b0;

        if (enable) begin
            phase_d = wrap ? '0 : phase_q + CNT_W'(1);
        end

        if (wrap) begin
            sec_d = sec_q + SEC_W'(1);
            hb_d  = sec_d[N_HB-1:0];
            // Only a shadow already pending before this cycle is applied; a
            // value accepted in the wrap cycle itself waits for the next wrap.
            if (shadow_vld_q) begin
                period_d     = shadow_q;
                shadow_vld_d = 1'b0;
            end
        end

        if (xfer) begin
            shadow_d     = CNT_W'(clamp_period(32'(period_in)));
            shadow_vld_d = 1'b1;
            ready_d      = 1'b0;
        end else if (!shadow_vld_q) begin
            // Re-open the slot one cycle after the shadow was consumed.
            ready_d = 1'b1;
        end

        // Reloading at every wrap keeps pps_o high when PULSE_CYC >= period.
        if (enable) begin
            if (wrap) begin
                pulse_cnt_d = PulseW'(PULSE_CYC);
                pps_d       = 1'b1;
            end else if (pulse_cnt_q > PulseW'(1)) begin
                pulse_cnt_d = pulse_cnt_q - PulseW'(1);
                pps_d       = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            phase_q      <= '0;
            period_q     <= CNT_W'(CLK_HZ);
            shadow_q     <= '0;
            shadow_vld_q <= 1'b0;
            ready_q      <= 1'b1;
            pulse_cnt_q  <= '0;
            pps_q        <= 1'b0;
            sec_q        <= SEC_INIT;
            hb_q         <= SEC_INIT[N_HB-1:0];
        end else begin
            phase_q      <= phase_d;
            period_q     <= period_d;
            shadow_q     <= shadow_d;
            shadow_vld_q <= shadow_vld_d;
            ready_q      <= ready_d;
            pulse_cnt_q  <= pulse_cnt_d;
            pps_q        <= pps_d;
            sec_q        <= sec_d;
            hb_q         <= hb_d;
        end
    end

    assign period_ready = ready_q;
    assign pps_o        = pps_q;
    assign sec_cnt_o    = sec_q;
    assign hb_o         = hb_q;
    assign phase_o      = phase_q;

endmodule

// File: tb/tb_pps_heartbeat_gen.sv
// Directed bench for pps_heartbeat_gen with a 10-cycle second.
//   dut_a : PULSE_CYC = 1
//   dut_b : PULSE_CYC = 4
//   dut_c : PULSE_CYC = 1, seconds counter preset to 2**32-1 at reset
// Cycle k is the state visible #1 after the k-th rising edge following reset release.
module tb_pps_heartbeat_gen;

    localparam int unsigned CW = 8;
    localparam int unsigned NH = 4;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          enable = 1'b1;
    logic [CW-1:0] period_in = '0;
    logic          period_valid = 1'b0;
    logic          ext_pps = 1'b0;

    logic          a_ready, a_pps, b_ready, b_pps, c_ready, c_pps;
    logic [31:0]   a_sec, b_sec, c_sec;
    logic [NH-1:0] a_hb, b_hb, c_hb;
    logic [CW-1:0] a_phase, a_align, b_phase, b_align, c_phase, c_align;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    pps_heartbeat_gen #(.CLK_HZ(10), .CNT_W(CW), .PULSE_CYC(1), .N_HB(NH)) dut_a (
        .clk(clk), .resetn(resetn), .enable(enable), .period_in(period_in),
        .period_valid(period_valid), .period_ready(a_ready), .ext_pps_i(ext_pps),
        .pps_o(a_pps), .sec_cnt_o(a_sec), .hb_o(a_hb), .phase_o(a_phase),
        .align_ofs_o(a_align)
    );

    pps_heartbeat_gen #(.CLK_HZ(10), .CNT_W(CW), .PULSE_CYC(4), .N_HB(NH)) dut_b (
        .clk(clk), .resetn(resetn), .enable(enable), .period_in(period_in),
        .period_valid(period_valid), .period_ready(b_ready), .ext_pps_i(ext_pps),
        .pps_o(b_pps), .sec_cnt_o(b_sec), .hb_o(b_hb), .phase_o(b_phase),
        .align_ofs_o(b_align)
    );

    pps_heartbeat_gen #(.CLK_HZ(10), .CNT_W(CW), .PULSE_CYC(1), .N_HB(NH),
                        .SEC_INIT(32'hFFFF_FFFF)) dut_c (
        .clk(clk), .resetn(resetn), .enable(enable), .period_in(period_in),
        .period_valid(period_valid), .period_ready(c_ready), .ext_pps_i(ext_pps),
        .pps_o(c_pps), .sec_cnt_o(c_sec), .hb_o(c_hb), .phase_o(c_phase),
        .align_ofs_o(c_align)
    );

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic step_to(input int k);
        while (cyc < k) step();
    endtask

    task automatic do_reset();
        resetn       = 1'b0;
        enable       = 1'b1;
        period_valid = 1'b0;
        period_in    = '0;
        ext_pps      = 1'b0;
        step();
        step();
        resetn = 1'b1;
        cyc    = 0;
    endtask

    task automatic test_reset();
        do_reset();
        if (a_phase !== 8'd0) begin
            $display("FAIL reset_phase got=%0d exp=0", a_phase); bad++;
        end
        total++;
        if (a_pps !== 1'b0) begin
            $display("FAIL reset_pps got=%b exp=0", a_pps); bad++;
        end
        total++;
        if (a_sec !== 32'd0) begin
            $display("FAIL reset_sec got=%0d exp=0", a_sec); bad++;
        end
        total++;
        if (a_hb !== 4'd0) begin
            $display("FAIL reset_hb got=%b exp=0000", a_hb); bad++;
        end
        total++;
        if (a_align !== 8'd0) begin
            $display("FAIL reset_align got=%0d exp=0", a_align); bad++;
        end
        total++;
        if (a_ready !== 1'b1) begin
            $display("FAIL reset_ready got=%b exp=1", a_ready); bad++;
        end
        total++;
        // Load a pending period, then reset asynchronously mid-cycle.
        period_in    = 8'd3;
        period_valid = 1'b1;
        step();
        period_valid = 1'b0;
        step_to(5);
        resetn = 1'b0;
        #2;
        if (a_phase !== 8'd0) begin
            $display("FAIL async_reset_phase got=%0d exp=0", a_phase); bad++;
        end
        total++;
        if (a_ready !== 1'b1) begin
            $display("FAIL async_reset_ready got=%b exp=1", a_ready); bad++;
        end
        total++;
        do_reset();
        // A surviving 3-cycle shadow would pulse at cycle 13.
        step_to(13);
        if (a_pps !== 1'b0) begin
            $display("FAIL reset_discard_shadow cyc=%0d got=%b exp=0", cyc, a_pps); bad++;
        end
        total++;
    endtask

    task automatic test_basic();
        logic exp_a, exp_b;
        do_reset();
        for (int k = 0; k <= 30; k++) begin
            step_to(k);
            exp_a = (k == 10) || (k == 20) || (k == 30);
            exp_b = (k >= 10) && ((k % 10) < 4);
            if (a_pps !== exp_a) begin
                $display("FAIL basic_pps cyc=%0d got=%b exp=%b", k, a_pps, exp_a); bad++;
            end
            total++;
            if (b_pps !== exp_b) begin
                $display("FAIL basic_pps_wide cyc=%0d got=%b exp=%b", k, b_pps, exp_b); bad++;
            end
            total++;
            if (a_phase !== 8'(k % 10)) begin
                $display("FAIL basic_phase cyc=%0d got=%0d exp=%0d", k, a_phase, k % 10); bad++;
            end
            total++;
        end
        if (a_sec !== 32'd3) begin
            $display("FAIL basic_sec got=%0d exp=3", a_sec); bad++;
        end
        total++;
        if (a_hb !== 4'b0011) begin
            $display("FAIL basic_hb got=%b exp=0011", a_hb); bad++;
        end
        total++;
    endtask

    task automatic test_period_load();
        logic exp_pps, exp_rdy;
        do_reset();
        for (int k = 0; k <= 21; k++) begin
            step_to(k);
            exp_pps = (k == 10) || (k == 15) || (k == 20);
            exp_rdy = (k < 4) || (k >= 11);
            if (a_pps !== exp_pps) begin
                $display("FAIL load_pps cyc=%0d got=%b exp=%b", k, a_pps, exp_pps); bad++;
            end
            total++;
            if (a_ready !== exp_rdy) begin
                $display("FAIL load_ready cyc=%0d got=%b exp=%b", k, a_ready, exp_rdy); bad++;
            end
            total++;
            if (k == 3) begin
                period_in    = 8'd5;
                period_valid = 1'b1;
            end
            if (k == 4) period_valid = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        logic exp_pps, exp_rdy;
        do_reset();
        for (int k = 0; k <= 27; k++) begin
            step_to(k);
            exp_pps = (k == 10) || (k == 14) || (k == 20) || (k == 26);
            exp_rdy = (k < 3) || (k == 11) || (k >= 15);
            if (a_pps !== exp_pps) begin
                $display("FAIL b2b_pps cyc=%0d got=%b exp=%b", k, a_pps, exp_pps); bad++;
            end
            total++;
            if (a_ready !== exp_rdy) begin
                $display("FAIL b2b_ready cyc=%0d got=%b exp=%b", k, a_ready, exp_rdy); bad++;
            end
            total++;
            if (k == 2) begin
                period_in    = 8'd4;
                period_valid = 1'b1;
            end
            if (k == 3) period_in = 8'd6;
            if (k == 12) period_valid = 1'b0;
        end
    endtask

    task automatic test_wrap_load();
        logic exp_pps, exp_rdy;
        do_reset();
        for (int k = 0; k <= 26; k++) begin
            step_to(k);
            exp_pps = (k == 10) || (k == 20) || (k == 23) || (k == 26);
            exp_rdy = (k <= 9) || (k >= 21);
            if (a_pps !== exp_pps) begin
                $display("FAIL wrapload_pps cyc=%0d got=%b exp=%b", k, a_pps, exp_pps); bad++;
            end
            total++;
            if (a_ready !== exp_rdy) begin
                $display("FAIL wrapload_ready cyc=%0d got=%b exp=%b", k, a_ready, exp_rdy); bad++;
            end
            total++;
            if (k == 9) begin
                period_in    = 8'd3;
                period_valid = 1'b1;
            end
            if (k == 10) period_valid = 1'b0;
        end
    endtask

    task automatic test_clamp();
        logic exp_a, exp_b;
        do_reset();
        for (int k = 0; k <= 20; k++) begin
            step_to(k);
            exp_a = (k == 10) || ((k > 10) && ((k % 2) == 0));
            exp_b = (k >= 10);
            if (a_pps !== exp_a) begin
                $display("FAIL clamp_pps cyc=%0d got=%b exp=%b", k, a_pps, exp_a); bad++;
            end
            total++;
            if (b_pps !== exp_b) begin
                $display("FAIL clamp_pps_wide cyc=%0d got=%b exp=%b", k, b_pps, exp_b); bad++;
            end
            total++;
            if (k == 0) begin
                period_in    = 8'd0;
                period_valid = 1'b1;
            end
            if (k == 1) period_valid = 1'b0;
        end
    endtask

    task automatic test_enable();
        logic exp_a, exp_b;
        do_reset();
        for (int k = 0; k <= 30; k++) begin
            step_to(k);
            exp_a = (k == 10) || (k == 24) || (k == 30);
            exp_b = ((k >= 10) && (k <= 12)) || ((k >= 24) && (k <= 27)) || (k == 30);
            if (a_pps !== exp_a) begin
                $display("FAIL en_pps cyc=%0d got=%b exp=%b", k, a_pps, exp_a); bad++;
            end
            total++;
            if (b_pps !== exp_b) begin
                $display("FAIL en_pps_wide cyc=%0d got=%b exp=%b", k, b_pps, exp_b); bad++;
            end
            total++;
            if ((k >= 12) && (k <= 16)) begin
                if (a_phase !== 8'd2) begin
                    $display("FAIL en_hold_phase cyc=%0d got=%0d exp=2", k, a_phase); bad++;
                end
                total++;
            end
            if (k == 17) begin
                if (a_phase !== 8'd3) begin
                    $display("FAIL en_resume_phase got=%0d exp=3", a_phase); bad++;
                end
                total++;
            end
            if (k == 14) begin
                if (a_ready !== 1'b0) begin
                    $display("FAIL en_handshake_ready got=%b exp=0", a_ready); bad++;
                end
                total++;
            end
            if (k == 24) begin
                if (a_sec !== 32'd2) begin
                    $display("FAIL en_sec got=%0d exp=2", a_sec); bad++;
                end
                total++;
            end
            if (k == 12) enable = 1'b0;
            if (k == 13) begin
                period_in    = 8'd6;
                period_valid = 1'b1;
            end
            if (k == 14) period_valid = 1'b0;
            if (k == 16) enable = 1'b1;
        end
    endtask

    task automatic test_sec_wrap();
        do_reset();
        step_to(9);
        if (c_sec !== 32'hFFFF_FFFF) begin
            $display("FAIL secwrap_pre got=%0h exp=ffffffff", c_sec); bad++;
        end
        total++;
        if (c_hb !== 4'hF) begin
            $display("FAIL secwrap_hb_pre got=%b exp=1111", c_hb); bad++;
        end
        total++;
        step_to(10);
        if (c_sec !== 32'd0) begin
            $display("FAIL secwrap_sec got=%0h exp=0", c_sec); bad++;
        end
        total++;
        if (c_hb !== 4'd0) begin
            $display("FAIL secwrap_hb got=%b exp=0000", c_hb); bad++;
        end
        total++;
        if (c_pps !== 1'b1) begin
            $display("FAIL secwrap_pps got=%b exp=1", c_pps); bad++;
        end
        total++;
    endtask

`ifdef PPS_ALIGN_EN
    task automatic test_align();
        do_reset();
        for (int k = 0; k <= 19; k++) begin
            step_to(k);
            if (k == 7) begin
                if (a_phase !== 8'd7) begin
                    $display("FAIL align_pre_phase got=%0d exp=7", a_phase); bad++;
                end
                total++;
            end
            if (k == 8) begin
                if ({a_pps, a_phase, a_align} !== {1'b1, 8'd0, 8'd7}) begin
                    $display("FAIL align_edge got=pps%b/ph%0d/ofs%0d exp=pps1/ph0/ofs7",
                             a_pps, a_phase, a_align); bad++;
                end
                total++;
                if (a_sec !== 32'd1) begin
                    $display("FAIL align_sec got=%0d exp=1", a_sec); bad++;
                end
                total++;
            end
            if (k == 18) begin
                if ({a_pps, a_phase, a_align} !== {1'b1, 8'd0, 8'd9}) begin
                    $display("FAIL align_coincide got=pps%b/ph%0d/ofs%0d exp=pps1/ph0/ofs9",
                             a_pps, a_phase, a_align); bad++;
                end
                total++;
            end
            if (k == 19) begin
                if (a_sec !== 32'd2) begin
                    $display("FAIL align_single_inc got=%0d exp=2", a_sec); bad++;
                end
                total++;
            end
            if (k == 4) ext_pps = 1'b1;
            if (k == 10) ext_pps = 1'b0;
            if (k == 14) ext_pps = 1'b1;
        end
    endtask
`else
    task automatic test_align();
        do_reset();
        for (int k = 0; k <= 10; k++) begin
            step_to(k);
            if (k == 8) begin
                if ({a_phase, a_align} !== {8'd8, 8'd0}) begin
                    $display("FAIL noalign_phase got=ph%0d/ofs%0d exp=ph8/ofs0", a_phase, a_align);
                    bad++;
                end
                total++;
            end
            if (k == 10) begin
                if ({a_pps, a_align} !== {1'b1, 8'd0}) begin
                    $display("FAIL noalign_pps got=pps%b/ofs%0d exp=pps1/ofs0", a_pps, a_align);
                    bad++;
                end
                total++;
            end
            if (k == 4) ext_pps = 1'b1;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_period_load();
        test_back_to_back();
        test_wrap_load();
        test_clamp();
        test_enable();
        test_sec_wrap();
        test_align();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
